// File: rtl/up_bus_pkg.sv
// Shared definitions for the up_* register bus: arbiter states, master indices
// and default bus widths used by the arbiter, register file and SPI master.
package up_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int UP_ADDR_W = 32;
    localparam int UP_DATA_W = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; purely combinational, the last-grant history
// register lives in the parent so this block has no state.
module rr_arb2
    import up_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_idx,
    output logic       gnt_vld
);

    always_comb begin
        gnt_vld = |req;
        gnt_idx = M0;
        if (req == 2'b11) begin
            gnt_idx = ~last_gnt;
        end else if (req[1]) begin
            gnt_idx = M1;
        end
    end

endmodule

// File: rtl/up_bus_arb.sv
// Two-master arbiter/sequencer for the shared up_* register bus: round-robin
// grant, single-cycle slave strobes, fixed-latency read capture, one-cycle ack.
//
// state | meaning
// IDLE  | no transaction; sample requests and latch the winner
// ISSUE | up_wr or up_rd strobe high; reads load the latency counter
// WAIT  | read in flight; capture up_data_rd when the counter hits 1
// ACK   | granted master's ack high for one cycle
module up_bus_arb
    import up_bus_pkg::*;
#(
    parameter int ADDR_W = UP_ADDR_W,
    parameter int DATA_W = UP_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              up_clk,
    input  logic              up_rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              up_wr,
    output logic              up_rd,
    output logic [ADDR_W-1:0] up_addr,
    output logic [DATA_W-1:0] up_data_wr,
    input  logic [DATA_W-1:0] up_data_rd,
    output logic              busy
);

    localparam int CNT_W = 4;

    state_t            state;
    logic              gnt;
    logic              we;
    logic              last_gnt;
    logic [CNT_W-1:0]  lat_cnt;

    logic              pick_idx;
    logic              pick_vld;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req      ({m1_req, m0_req}),
        .last_gnt (last_gnt),
        .gnt_idx  (pick_idx),
        .gnt_vld  (pick_vld)
    );

    assign sel_we    = (pick_idx == M1) ? m1_we    : m0_we;
    assign sel_addr  = (pick_idx == M1) ? m1_addr  : m0_addr;
    assign sel_wdata = (pick_idx == M1) ? m1_wdata : m0_wdata;

    always_ff @(posedge up_clk or negedge up_rst_n) begin
        if (!up_rst_n) begin
            state      <= IDLE;
            gnt        <= M0;
            we         <= 1'b0;
            last_gnt   <= M1;
            lat_cnt    <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            up_wr      <= 1'b0;
            up_rd      <= 1'b0;
            up_addr    <= '0;
            up_data_wr <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt        <= pick_idx;
                        last_gnt   <= pick_idx;
                        we         <= sel_we;
                        up_addr    <= sel_addr;
                        up_data_wr <= sel_wdata;
                        up_wr      <= sel_we;
                        up_rd      <= ~sel_we;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    up_wr <= 1'b0;
                    up_rd <= 1'b0;
                    if (we) begin
                        m0_ack <= (gnt == M0);
                        m1_ack <= (gnt == M1);
                        state  <= ACK;
                    end else begin
                        lat_cnt <= CNT_W'(RD_LAT);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - CNT_W'(1);
                    // counter value 1 marks the cycle up_data_rd is valid
                    if (lat_cnt == CNT_W'(1)) begin
                        if (gnt == M1) begin
                            m1_rdata <= up_data_rd;
                        end else begin
                            m0_rdata <= up_data_rd;
                        end
                        m0_ack <= (gnt == M0);
                        m1_ack <= (gnt == M1);
                        state  <= ACK;
                    end
                end
                ACK: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
